// File: rtl/breakout_paddle_ctrl_if.sv
// Button, frame-sync and paddle-position signals exchanged between the
// paddle controller and its surroundings.
interface breakout_paddle_ctrl_if;
    logic       btn_left;
    logic       btn_right;
    logic       vSync;
    logic [9:0] PaddleX;
    logic [1:0] moving;
    logic       at_edge;

    modport master (
        output btn_left, btn_right, vSync,
        input  PaddleX, moving, at_edge
    );

    modport slave (
        input  btn_left, btn_right, vSync,
        output PaddleX, moving, at_edge
    );
endinterface

// File: rtl/breakout_paddle_ctrl.sv
// Debounced two-button paddle controller; moves PaddleX once per vSync rising edge.
// Define PADDLE_WRAP_EN to wrap around the playfield instead of clamping at its limits.
module breakout_paddle_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SPEED_MIN       = 2,
    parameter int SPEED_MAX       = 8,
    parameter int ACCEL_FRAMES    = 4,
    parameter int PADDLE_MIN      = 0,
    parameter int PADDLE_MAX      = 960,
    parameter int PADDLE_RESET    = 900
) (
    input logic                   clk,
    input logic                   rst_n,
    breakout_paddle_ctrl_if.slave pif
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int AC_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AC_W-1:0] ACC_LAST = AC_W'(ACCEL_FRAMES - 1);
    localparam logic [10:0]     S_MIN    = 11'(SPEED_MIN);
    localparam logic [10:0]     S_MAX    = 11'(SPEED_MAX);
    localparam logic [10:0]     P_MIN    = 11'(PADDLE_MIN);
    localparam logic [10:0]     P_MAX    = 11'(PADDLE_MAX);
    localparam logic [10:0]     P_RESET  = 11'(PADDLE_RESET);
`ifdef PADDLE_WRAP_EN
    localparam logic [10:0]     P_SPAN   = 11'(PADDLE_MAX - PADDLE_MIN + 1);
`endif

    typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_e;
    typedef enum logic [1:0] {DIR_NONE, DIR_L, DIR_R} dir_e;

    // Bit 1 is the left button, bit 0 the right button throughout.
    logic [1:0]      sync1_q, sync2_q, deb_q;
    logic [DB_W-1:0] db_cnt_q [2];

    logic            vsync_d_q;
    state_e          state_q;
    logic [10:0]     speed_q;
    logic [AC_W-1:0] accel_q;
    logic [10:0]     pos_q;
    logic [1:0]      moving_q;
    logic            at_edge_q;

    logic            tick;
    dir_e            dir;
    logic            same_dir;
    logic [10:0]     step_spd, sum, right_pos, left_pos, pos_d;
    logic            over, under, edge_d;

    // NOTE: every clocked register is written with <= so all of them sample
    // the pre-edge values; the debounce counters are few enough to reset too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= {pif.btn_left, pif.btn_right};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    deb_q[i]    <= ~deb_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign tick = pif.vSync & ~vsync_d_q;

    always_comb begin
        case (deb_q)
            2'b10:   dir = DIR_L;
            2'b01:   dir = DIR_R;
            default: dir = DIR_NONE;
        endcase
    end

    assign same_dir = ((dir == DIR_L) && (state_q == MOVE_L)) ||
                      ((dir == DIR_R) && (state_q == MOVE_R));
    assign step_spd = same_dir ? speed_q : S_MIN;
    assign sum      = pos_q + step_spd;
    assign over     = sum > P_MAX;
    assign under    = pos_q < (P_MIN + step_spd);

    // NOTE: pos_d gets a default before any branch so no latch is inferred.
    always_comb begin
`ifdef PADDLE_WRAP_EN
        right_pos = over  ? (sum - P_SPAN) : sum;
        left_pos  = under ? (pos_q + P_SPAN - step_spd) : (pos_q - step_spd);
`else
        right_pos = over  ? P_MAX : sum;
        left_pos  = under ? P_MIN : (pos_q - step_spd);
`endif
        pos_d = pos_q;
        if (dir == DIR_R)      pos_d = right_pos;
        else if (dir == DIR_L) pos_d = left_pos;
`ifdef PADDLE_WRAP_EN
        edge_d = ((dir == DIR_R) && over) || ((dir == DIR_L) && under);
`else
        edge_d = (pos_d == P_MIN) || (pos_d == P_MAX);
`endif
    end

    // Motion state machine; everything except the wrap pulse holds between ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d_q <= 1'b0;
            state_q   <= IDLE;
            speed_q   <= S_MIN;
            accel_q   <= '0;
            pos_q     <= P_RESET;
            moving_q  <= 2'b00;
            at_edge_q <= 1'b0;
        end else begin
            vsync_d_q <= pif.vSync;
            if (tick) begin
                pos_q     <= pos_d;
                at_edge_q <= edge_d;
                case (dir)
                    DIR_NONE: begin
                        state_q  <= IDLE;
                        speed_q  <= S_MIN;
                        accel_q  <= '0;
                        moving_q <= 2'b00;
                    end
                    default: begin
                        moving_q <= (dir == DIR_L) ? 2'b10 : 2'b01;
                        if (same_dir) begin
                            if (accel_q == ACC_LAST) begin
                                accel_q <= '0;
                                speed_q <= (speed_q >= S_MAX) ? S_MAX : speed_q + 11'd1;
                            end else begin
                                accel_q <= accel_q + 1'b1;
                            end
                        end else begin
                            state_q <= (dir == DIR_L) ? MOVE_L : MOVE_R;
                            speed_q <= S_MIN;
                            accel_q <= '0;
                        end
                    end
                endcase
            end
`ifdef PADDLE_WRAP_EN
            else begin
                at_edge_q <= 1'b0;
            end
`endif
        end
    end

    assign pif.PaddleX = pos_q[9:0];
    assign pif.moving  = moving_q;
    assign pif.at_edge = at_edge_q;

endmodule

// File: tb/tb_breakout_paddle_ctrl.sv
// Directed bench for breakout_paddle_ctrl: debounce, acceleration, limits, reset.
// Honours PADDLE_WRAP_EN for the playfield-limit section.
module tb_breakout_paddle_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    breakout_paddle_ctrl_if pif ();

    breakout_paddle_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .SPEED_MIN      (2),
        .SPEED_MAX      (6),
        .ACCEL_FRAMES   (2),
        .PADDLE_MIN     (0),
        .PADDLE_MAX     (960),
        .PADDLE_RESET   (900)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .pif  (pif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int exp_ramp [13] = '{902, 904, 906, 909, 912, 916, 920, 925, 930, 936, 942, 948, 954};
    int exp_rst  [8]  = '{904, 906, 909, 912, 916, 920, 925, 930};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One 50-clk frame: vSync low first so button changes settle, then high.
    task automatic frame(input int high = 1);
        pif.vSync = 1'b0;
        repeat (50 - high) @(negedge clk);
        pif.vSync = 1'b1;
        repeat (high) @(negedge clk);
        pif.vSync = 1'b0;
    endtask

    task automatic set_btn(input logic l, input logic r);
        pif.btn_left  = l;
        pif.btn_right = r;
    endtask

    task automatic check_out(input string tag, input int x, input int mv, input int edg);
        check({tag, "_x"},    32'(pif.PaddleX), 32'(x));
        check({tag, "_mv"},   32'(pif.moving),  32'(mv));
        check({tag, "_edge"}, 32'(pif.at_edge), 32'(edg));
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        set_btn(1'b0, 1'b0);
        pif.vSync = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_out("reset", 900, 0, 0);
        rst_n = 1'b1;

        // Idle frames
        for (int f = 0; f < 5; f++) begin
            frame();
            check_out($sformatf("idle%0d", f), 900, 0, 0);
        end

        // Short glitches never reach the debounced level
        for (int g = 0; g < 6; g++) begin
            pif.btn_right = 1'b1;
            repeat (3) @(negedge clk);
            pif.btn_right = 1'b0;
            repeat (3) @(negedge clk);
        end
        check("glitch_deb", 32'(dut.deb_q[0]), 32'd0);
        frame();
        check_out("glitch", 900, 0, 0);

        // A held press rises after 2 sync + 4 stable clocks
        pif.btn_right = 1'b1;
        repeat (5) @(negedge clk);
        check("deb_early", 32'(dut.deb_q[0]), 32'd0);
        @(negedge clk);
        check("deb_rise", 32'(dut.deb_q[0]), 32'd1);

        // Acceleration ramp to the speed cap
        for (int i = 0; i < 13; i++) begin
            frame();
            check_out($sformatf("ramp%0d", i), exp_ramp[i], 1, 0);
        end

`ifdef PADDLE_WRAP_EN
        frame();
        check_out("wrap_r0", 960, 1, 0);
        frame();
        check_out("wrap_r1", 5, 1, 1);
        @(negedge clk);
        check("wrap_r1_pulse_end", 32'(pif.at_edge), 32'd0);
        set_btn(1'b1, 1'b0);
        frame();
        check_out("wrap_l0", 3, 2, 0);
        frame();
        check_out("wrap_l1", 1, 2, 0);
        frame();
        check_out("wrap_l2", 960, 2, 1);
        @(negedge clk);
        check("wrap_l2_pulse_end", 32'(pif.at_edge), 32'd0);
`else
        frame();
        check_out("clamp_r0", 960, 1, 1);
        frame();
        check_out("clamp_r1", 960, 1, 1);

        // Reversal, then both/neither, then fresh press and reversal
        set_btn(1'b1, 1'b0);
        frame();
        check_out("rev_l0", 958, 2, 0);
        frame();
        check_out("rev_l1", 956, 2, 0);
        set_btn(1'b1, 1'b1);
        for (int f = 0; f < 3; f++) begin
            frame();
            check_out($sformatf("both%0d", f), 956, 0, 0);
        end
        set_btn(1'b0, 1'b0);
        frame();
        check_out("neither", 956, 0, 0);
        set_btn(1'b0, 1'b1);
        frame();
        check_out("fresh_r", 958, 1, 0);
        set_btn(1'b1, 1'b0);
        frame();
        check_out("rev_again", 956, 2, 0);

        // Run into the left wall and stay there
        for (int f = 0; f < 200; f++) frame();
        check_out("left_wall", 0, 2, 1);
`endif

        // Held-high vSync yields a single tick; reset mid-move
        set_btn(1'b0, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pif.vSync = 1'b0;
        repeat (40) @(negedge clk);
        pif.vSync = 1'b1;
        @(negedge clk);
        check("vs_hold_first", 32'(pif.PaddleX), 32'd902);
        repeat (9) @(negedge clk);
        check("vs_hold_last", 32'(pif.PaddleX), 32'd902);
        pif.vSync = 1'b0;
        for (int i = 0; i < 8; i++) begin
            frame();
            check_out($sformatf("pre_rst%0d", i), exp_rst[i], 1, 0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 900, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_btn(1'b0, 1'b0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
